// File: rtl/fcmp_unit.sv
// fcmp_unit: two-stage pipelined binary32 compare unit (FEQ / FLT / FLE).
// S1 captures the issue packet, S2 holds the compare result and drives out_* from flops.
//
// Handshake: a packet moves on a rising edge when its valid and the receiver's ready are both high.
// The producer holds valid and the payload stable until that edge.
// in_ready is combinational from out_ready, and nothing that depends on in_valid reaches out_valid.
module fcmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ill
);

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    // Stage 1 registers. Only s1_v is reset; the payload may hold stale data.
    logic             s1_v;
    op_e              s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_x1;
    logic [31:0]      s1_x2;

    // Pipeline advance enables. Stage 2 valid is out_valid itself.
    logic s2_en;
    logic s1_en;

    // Compare datapath signals, all derived from the S1 operands.
    logic        x1_s, x2_s;
    logic [7:0]  x1_e, x2_e;
    logic [22:0] x1_m, x2_m;
    logic        exp_lt, exp_gt, exp_eq;
    logic        mag_lt, mag_gt;
    logic        lt, eq, cmp, ill;

    // Advance logic.
    // A flush empties the pipe on this edge, so in_ready is held high during a flush.
    // Any packet taken on that edge is discarded.
    always_comb begin
        s2_en    = !out_valid || out_ready;
        s1_en    = !s1_v || s2_en;
        in_ready = s1_en || flush;
    end

    // Sign-magnitude less-than and bitwise equality on the S1 operands.
    // There is no NaN or infinity handling, and -0 orders below +0.
    always_comb begin
        x1_s   = s1_x1[31];
        x2_s   = s1_x2[31];
        x1_e   = s1_x1[30:23];
        x2_e   = s1_x2[30:23];
        x1_m   = s1_x1[22:0];
        x2_m   = s1_x2[22:0];
        exp_lt = x1_e < x2_e;
        exp_gt = x1_e > x2_e;
        exp_eq = x1_e == x2_e;
        // The exponent decides first; the mantissa breaks an exponent tie.
        mag_lt = exp_lt || (exp_eq && (x1_m < x2_m));
        mag_gt = exp_gt || (exp_eq && (x1_m > x2_m));
        eq     = s1_x1 == s1_x2;
        lt     = 1'b0;
        case ({x1_s, x2_s})
            2'b00:   lt = mag_lt;
            2'b01:   lt = 1'b0;
            2'b10:   lt = 1'b1;
            default: lt = mag_gt;
        endcase
        cmp = 1'b0;
        ill = 1'b0;
        case (s1_op)
            OP_FEQ:  cmp = eq;
            OP_FLT:  cmp = lt;
            OP_FLE:  cmp = lt || eq;
            default: ill = 1'b1;
        endcase
    end

    // Valid bits and the S2 output register.
    // Reset is asynchronous; flush clears both valids.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_tag   <= '0;
            out_ill   <= 1'b0;
        end else if (flush) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_en) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_data <= {31'd0, cmp};
                    out_tag  <= s1_tag;
                    out_ill  <= ill;
                end
            end
            if (s1_en) begin
                s1_v <= in_valid;
            end
        end
    end

    // S1 payload capture. It needs no reset because s1_v qualifies it.
    always_ff @(posedge clk) begin
        if (in_valid && s1_en) begin
            s1_op  <= op_e'(in_op);
            s1_tag <= in_tag;
            s1_x1  <= in_x1;
            s1_x2  <= in_x2;
        end
    end

endmodule
